// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit for the RV32M operations.
// Multiply is shift-add and divide is restoring, one bit per cycle over the operand magnitudes,
// with sign correction applied in a single finishing cycle.
// Optional feature macro: MULDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier bits
// are all zero, realigning the partial product in the finishing cycle.
module muldiv_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ITER_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] C
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    localparam logic [ITER_W-1:0] LastIter = ITER_W'(XLEN - 1);

    state_e              state_q;
    logic [2:0]          op_q;
    logic                neg_q;    // negate product / quotient in the finishing cycle
    logic                sa_q;     // negate remainder (sign of A)
    logic [XLEN-1:0]     opb_q;    // multiplicand |A| or divisor |B|
    logic [XLEN-1:0]     shreg_q;  // multiplier |B|, or dividend shifting into quotient
    logic [XLEN-1:0]     rem_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [ITER_W-1:0]   cnt_q;

    // Operand decode for accept: sign flags, magnitudes and fast-path detection
    logic            signed_a, signed_b, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign signed_a = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign signed_b = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign a_neg    = signed_a & A[XLEN-1];
    assign b_neg    = signed_b & B[XLEN-1];
    assign a_mag    = a_neg ? -A : A;
    assign b_mag    = b_neg ? -B : B;
    assign div_zero = op[2] && (B == '0);
    assign div_ovf  = op[2] && !op[0] && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);

    // Datapath for one iteration
    logic [XLEN:0] add_sum, shifted, trial;

    assign add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    assign shifted = {rem_q, shreg_q[XLEN-1]};
    assign trial   = shifted - {1'b0, opb_q};

    // Finishing-cycle sign correction and result selection
    logic [2*XLEN-1:0] acc_fin, prod;
    logic [XLEN-1:0]   quo, rmd, result;

`ifdef MULDIV_EARLY_OUT_EN
    // Skipped iterations never shifted the accumulator; realign it here.
    assign acc_fin = acc_q >> (ITER_W'(XLEN) - cnt_q);
`else
    assign acc_fin = acc_q;
`endif
    assign prod = neg_q ? -acc_fin : acc_fin;
    assign quo  = neg_q ? -shreg_q : shreg_q;
    assign rmd  = sa_q ? -rem_q : rem_q;

    // Select the architectural result for the latched op
    always_comb begin
        result = rmd;
        case (op_q)
            3'd0:             result = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       result = quo;
            default:          ;
        endcase
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            opb_q   <= '0;
            shreg_q <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            C       <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q  <= op;
                        acc_q <= '0;
                        cnt_q <= '0;
                        busy  <= 1'b1;
                        if (div_zero) begin
                            shreg_q <= '1;
                            rem_q   <= A;
                            neg_q   <= 1'b0;
                            sa_q    <= 1'b0;
                            state_q <= StFin;
                        end else if (div_ovf) begin
                            shreg_q <= {1'b1, {(XLEN-1){1'b0}}};
                            rem_q   <= '0;
                            neg_q   <= 1'b0;
                            sa_q    <= 1'b0;
                            state_q <= StFin;
                        end else begin
                            neg_q   <= a_neg ^ b_neg;
                            sa_q    <= a_neg;
                            rem_q   <= '0;
                            shreg_q <= op[2] ? a_mag : b_mag;
                            opb_q   <= op[2] ? b_mag : a_mag;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (!op_q[2]) begin
                        acc_q   <= shreg_q[0] ? {add_sum, acc_q[XLEN-1:1]}
                                              : {1'b0, acc_q[2*XLEN-1:1]};
                        shreg_q <= shreg_q >> 1;
                    end else begin
                        shreg_q <= {shreg_q[XLEN-2:0], ~trial[XLEN]};
                        rem_q   <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
                    end
                    cnt_q <= cnt_q + ITER_W'(1);
`ifdef MULDIV_EARLY_OUT_EN
                    if ((cnt_q == LastIter) || (!op_q[2] && (shreg_q[XLEN-1:1] == '0))) begin
                        state_q <= StFin;
                    end
`else
                    if (cnt_q == LastIter) begin
                        state_q <= StFin;
                    end
`endif
                end
                StFin: begin
                    C       <= result;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed self-checking bench for muldiv_unit against an
// arithmetic reference model of the RV32M results and of the expected completion latency.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] c;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32), .ITER_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .C     (c)
    );

    always #5 clk = ~clk;

    // RV32M result from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        logic [63:0]     p;
        logic            ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'(uy); return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    // Number of clock edges after the accepting edge until done is visible
    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
        if (o[2] && (y == 0)) return 1;
        if (o[2] && !o[0] && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[2]) begin
            logic [31:0] m;
            int          cnt;
            m   = ((o == 3'd1) && y[31]) ? -y : y;
            cnt = 1;
            for (int i = 0; i < 32; i++) if (m[i]) cnt = i + 1;
            return cnt + 1;
        end
`endif
        return 33;
    endfunction

    // Issue one operation and wait (bounded) for done; timeout reported to caller
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output bit timeout);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = 0;
        timeout = 1'b1;
        for (int i = 0; i < 60 && timeout; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) timeout = 1'b0;
        end
        res = c;
    endtask

    task automatic recover();
        rst_n = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (c !== 32'h0) begin n_fail++; $display("FAIL reset_c got %h want 0", c); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  ops [13] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7,
                                  3'd4, 3'd6, 3'd0, 3'd0};
        logic [31:0] as  [13] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  -32'd7, -32'd7, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                                  32'h8000_0000, 32'd3, 32'd3};
        logic [31:0] bs  [13] = '{32'd6, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                  32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
                                  32'd0};
        logic [31:0] cs  [13] = '{32'd42, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'hFFFF_FFFF, 32'd5,
                                  32'h8000_0000, 32'd0, 32'd3, 32'd0};
        logic [31:0] res;
        int          lat;
        bit          to;
        for (int i = 0; i < 13; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, to);
            n_checks++;
            if (to) begin
                n_fail++; $display("FAIL directed_%0d_timeout got no done want done", i);
                recover();
            end else begin
                if (res !== cs[i]) begin
                    n_fail++; $display("FAIL directed_%0d_result got %h want %h", i, res, cs[i]);
                end
                n_checks++;
                if (lat != exp_lat(ops[i], as[i], bs[i])) begin
                    n_fail++;
                    $display("FAIL directed_%0d_latency got %0d want %0d", i, lat,
                             exp_lat(ops[i], as[i], bs[i]));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, res, want;
        logic [2:0]  o;
        int          lat;
        bit          to;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(0, 255));
                3: x = 32'($urandom_range(0, 15));
                default: ;
            endcase
            want = model(o, x, y);
            run_op(o, x, y, res, lat, to);
            n_checks++;
            if (to) begin
                n_fail++; $display("FAIL random_%0d_timeout got no done want done", i);
                recover();
            end else begin
                if (res !== want) begin
                    n_fail++;
                    $display("FAIL random_%0d_op%0d a=%h b=%h got %h want %h", i, o, x, y,
                             res, want);
                end
                n_checks++;
                if (lat != exp_lat(o, x, y)) begin
                    n_fail++;
                    $display("FAIL random_%0d_latency got %0d want %0d", i, lat,
                             exp_lat(o, x, y));
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] res;
        int          lat;
        bit          to;
        run_op(3'd7, 32'd1000, 32'd33, res, lat, to);
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL hold_done_pulse got %b want 0", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy got %b want 0", busy); end
        a = 32'hDEAD_BEEF; b = 32'h1234;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (c !== 32'd10) begin n_fail++; $display("FAIL hold_c got %h want %h", c, 32'd10); end
    endtask

    task automatic test_ignore_start();
        int  lat;
        bit  to;
        bit  extra;
        @(negedge clk);
        op = 3'd0; a = 32'd7; b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got %b want 1", busy); end
        lat = 0; to = 1'b1;
        for (int i = 0; i < 60 && to; i++) begin
            @(negedge clk);
            if (i == 5) begin start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7; end
            else start = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (done) to = 1'b0;
        end
        start = 1'b0;
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL ignore_timeout got no done want done"); recover();
        end else if (c !== 32'd42) begin
            n_fail++; $display("FAIL ignore_result got %h want %h", c, 32'd42);
        end
        n_checks++;
        if (lat != exp_lat(3'd0, 32'd7, 32'd6)) begin
            n_fail++;
            $display("FAIL ignore_latency got %0d want %0d", lat, exp_lat(3'd0, 32'd7, 32'd6));
        end
        extra = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) extra = 1'b1; end
        n_checks++;
        if (extra) begin n_fail++; $display("FAIL ignore_second_done got 1 want 0"); end
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++;
        if (c !== 32'h0) begin n_fail++; $display("FAIL abort_c got %h want 0", c); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL abort_done got 1 want 0"); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        bit          to;
        run_op(3'd4, -32'd100, 32'd7, res, lat, to);
        n_checks++;
        if (to || res !== 32'hFFFF_FFF2) begin
            n_fail++; $display("FAIL b2b_first got %h want %h", res, 32'hFFFF_FFF2);
        end
        // Issued from the done cycle of the previous operation
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, res, lat, to);
        n_checks++;
        if (to || res !== 32'h4000_0000) begin
            n_fail++; $display("FAIL b2b_second got %h want %h", res, 32'h4000_0000);
        end
        n_checks++;
        if (lat != exp_lat(3'd1, 32'h8000_0000, 32'h8000_0000)) begin
            n_fail++;
            $display("FAIL b2b_latency got %0d want %0d", lat,
                     exp_lat(3'd1, 32'h8000_0000, 32'h8000_0000));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
